ifetch_buf: RTL and testbench

Parametrised instruction-fetch front end that sits between the branch/PC logic and decode. It fetches from a local single-cycle IMEM region or, above that region, from an external variable-latency instruction port. Fetched words go into an in-order prefetch FIFO with per-entry PC, so decode stalls no longer throttle fetch. Branches flush the FIFO and discard in-flight responses.

---
 rtl/ifetch_buf.sv | 185 ++++++++++++++++++
 tb/tb_ifetch_buf.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_buf.sv
// ifetch_buf: instruction fetch front end. Fetches from a single-cycle local IMEM
// below 2**IMEM_AW or from a variable-latency external port above it, and queues
// fetched words with their PCs in an in-order prefetch FIFO.
// Optional feature macro IFETCH_MISALIGN_EN: misaligned branch targets pulse
// misalign and halt fetch until the next aligned branch.
module ifetch_buf #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int unsigned IMEM_AW = 11,
    parameter int unsigned DEPTH   = 4
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               stall,
    input  logic               br_en,
    input  logic [31:0]        br_addr,
    output logic               ins_valid,
    output logic [31:0]        ins_out,
    output logic [31:0]        ins_pc,
    output logic               imem_ren,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               ex_req,
    output logic [31:0]        ex_addr,
    input  logic               ex_ack,
    input  logic [31:0]        ex_rdata,
    output logic               misalign
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] LocalMax = 32'((64'd1 << IMEM_AW) - 64'd4);
    localparam logic [31:0] ExBase   = 32'(64'd1 << IMEM_AW);

    typedef logic [CW:0] sum_t;
    typedef enum logic {ExIdle, ExWait} ex_st_e;

    logic [31:0]   fpc_q, fpc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic          lfl_q, lfl_d;
    logic [31:0]   lpc_q, lpc_d;
    ex_st_e        ex_st_q, ex_st_d;
    logic          drop_q, drop_d;
    logic [31:0]   ex_addr_q, ex_addr_d;
    logic [31:0]   hold_ins_q, hold_ins_d, hold_pc_q, hold_pc_d;
    logic [31:0]   fifo_ins_q [DEPTH];
    logic [31:0]   fifo_pc_q  [DEPTH];

    logic        halt, pop, space_ok, is_local, can_issue, local_issue, ex_issue;
    logic        ex_done, push_local, push_ex, push;
    logic [31:0] push_data, push_pc;

`ifdef IFETCH_MISALIGN_EN
    logic halt_q, mis_q, mis_br;

    assign mis_br   = br_en & (br_addr[1:0] != 2'b00);
    assign halt     = halt_q;
    assign misalign = mis_q;

    // Misaligned branch: one-cycle pulse, and fetch stays halted until an aligned branch.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            halt_q <= 1'b0;
            mis_q  <= 1'b0;
        end else begin
            halt_q <= br_en ? mis_br : halt_q;
            mis_q  <= mis_br;
        end
    end
`else
    assign halt     = 1'b0;
    assign misalign = 1'b0;
`endif

    assign ins_valid = (cnt_q != '0);
    assign ins_out   = ins_valid ? fifo_ins_q[rd_ptr_q] : hold_ins_q;
    assign ins_pc    = ins_valid ? fifo_pc_q[rd_ptr_q] : hold_pc_q;
    assign ex_req    = (ex_st_q == ExWait);
    assign ex_addr   = ex_addr_q;
    assign imem_ren  = local_issue;
    assign imem_addr = fpc_q[IMEM_AW-1:0];

    // Issue decision and push selection; a branch suppresses issue and any push.
    always_comb begin
        pop         = ins_valid & ~stall;
        // An in-flight local word already owns a slot.
        space_ok    = (sum_t'(cnt_q) + sum_t'(lfl_q)) < (sum_t'(DEPTH) + sum_t'(pop));
        is_local    = (fpc_q <= LocalMax);
        can_issue   = nrst & ~br_en & ~halt & space_ok & (ex_st_q == ExIdle);
        local_issue = can_issue & is_local;
        ex_issue    = can_issue & ~is_local & ~lfl_q;
        ex_done     = (ex_st_q == ExWait) & ex_ack;
        push_local  = lfl_q & ~br_en;
        push_ex     = ex_done & ~drop_q & ~br_en;
        push        = push_local | push_ex;
        push_data   = lfl_q ? imem_rdata : ex_rdata;
        // The external word's PC is still fpc, which only advances on its ack.
        push_pc     = lfl_q ? lpc_q : fpc_q;
    end

    // Next-state for fetch PC, FIFO bookkeeping and the external request FSM.
    always_comb begin
        fpc_d      = fpc_q;
        cnt_d      = cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        lfl_d      = local_issue;
        lpc_d      = local_issue ? fpc_q : lpc_q;
        ex_st_d    = ex_st_q;
        drop_d     = drop_q;
        ex_addr_d  = ex_addr_q;
        hold_ins_d = ins_valid ? fifo_ins_q[rd_ptr_q] : hold_ins_q;
        hold_pc_d  = ins_valid ? fifo_pc_q[rd_ptr_q] : hold_pc_q;

        if (br_en) begin
            fpc_d    = br_addr & 32'hFFFF_FFFC;
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (local_issue || (ex_done && !drop_q)) begin
                fpc_d = fpc_q + 32'd4;
            end
            cnt_d    = cnt_q + CW'(push) - CW'(pop);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
        end

        unique case (ex_st_q)
            ExIdle: begin
                if (ex_issue) begin
                    ex_st_d   = ExWait;
                    ex_addr_d = fpc_q - ExBase;
                end
            end
            ExWait: begin
                if (ex_ack) begin
                    ex_st_d = ExIdle;
                    drop_d  = 1'b0;
                end else if (br_en) begin
                    drop_d = 1'b1;
                end
            end
            default: ex_st_d = ExIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            fpc_q      <= PC_INIT;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            lfl_q      <= 1'b0;
            lpc_q      <= '0;
            ex_st_q    <= ExIdle;
            drop_q     <= 1'b0;
            ex_addr_q  <= '0;
            hold_ins_q <= '0;
            hold_pc_q  <= '0;
        end else begin
            fpc_q      <= fpc_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            lfl_q      <= lfl_d;
            lpc_q      <= lpc_d;
            ex_st_q    <= ex_st_d;
            drop_q     <= drop_d;
            ex_addr_q  <= ex_addr_d;
            hold_ins_q <= hold_ins_d;
            hold_pc_q  <= hold_pc_d;
        end
    end

    // FIFO storage; contents need no reset because cnt gates visibility.
    always_ff @(posedge clk) begin
        if (nrst && push) begin
            fifo_ins_q[wr_ptr_q] <= push_data;
            fifo_pc_q[wr_ptr_q]  <= push_pc;
        end
    end

endmodule

// File: tb/tb_ifetch_buf.sv
// Bench for ifetch_buf: directed timing steps followed by a randomized stream checked
// against a PC-sequence model (every delivered word must be the next PC in program
// order from the last branch target, carrying that address's memory contents).
module tb_ifetch_buf;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        stall = 1'b0;
    logic        br_en = 1'b0;
    logic [31:0] br_addr = '0;
    logic        ins_valid;
    logic [31:0] ins_out, ins_pc;
    logic        imem_ren;
    logic [10:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        ex_req;
    logic [31:0] ex_addr;
    logic        ex_ack = 1'b0;
    logic [31:0] ex_rdata = '0;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    // External agent controls (written by the stimulus block only).
    int          ex_lat = 3;
    bit          rand_lat = 1'b0;
    bit          force_en = 1'b0;
    logic [31:0] force_val = '0;
    // Agent-owned state.
    int          wcnt = 0;
    int          cur_lat = 0;

    always #5 clk = ~clk;

    ifetch_buf #(
        .PC_INIT (32'h0000_0000),
        .IMEM_AW (11),
        .DEPTH   (4)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .stall      (stall),
        .br_en      (br_en),
        .br_addr    (br_addr),
        .ins_valid  (ins_valid),
        .ins_out    (ins_out),
        .ins_pc     (ins_pc),
        .imem_ren   (imem_ren),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .ex_req     (ex_req),
        .ex_addr    (ex_addr),
        .ex_ack     (ex_ack),
        .ex_rdata   (ex_rdata),
        .misalign   (misalign)
    );

    // Memory contents seen at any instruction address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Local IMEM: data the cycle after a read; junk otherwise.
    always @(posedge clk) begin
        imem_rdata <= imem_ren ? mem_word(32'(imem_addr)) : $urandom();
    end

    // External agent: acks a request after cur_lat extra cycles.
    always @(negedge clk) begin
        ex_ack   = 1'b0;
        ex_rdata = $urandom();
        if (!nrst || !ex_req) begin
            wcnt = 0;
        end else begin
            if (wcnt == 0) cur_lat = rand_lat ? int'($urandom_range(0, 3)) : ex_lat;
            if (wcnt >= cur_lat) begin
                ex_ack   = 1'b1;
                ex_rdata = force_en ? force_val : mem_word(ex_addr + 32'h800);
                wcnt     = 0;
            end else begin
                wcnt++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Holds reset, checks reset outputs, then releases reset; returns in cycle 0.
    task automatic do_reset(input bit st);
        nrst    = 1'b0;
        br_en   = 1'b0;
        br_addr = '0;
        stall   = st;
        repeat (3) tick();
        #1;
        chk("rst_valid", ins_valid, 1'b0);
        chk("rst_out", ins_out, 32'h0);
        chk("rst_pc", ins_pc, 32'h0);
        chk("rst_ren", imem_ren, 1'b0);
        chk("rst_exreq", ex_req, 1'b0);
        chk("rst_exaddr", ex_addr, 32'h0);
        chk("rst_misalign", misalign, 1'b0);
        tick();
        nrst = 1'b1;
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 3))
            0:       return {21'b0, r[10:2], 2'b00};
            1:       return 32'h7E0 + {26'b0, r[5:2], 2'b00};
            2:       return 32'hFFFF_FFE0 + {27'b0, r[4:2], 2'b00};
            default: return {r[31:2], 2'b00};
        endcase
    endfunction

    logic [31:0] exp_pc, last_out, last_pc, prev_addr;
    logic        prev_req, prev_ack;
    int          pops;
    bit          seen;

    initial begin
        // Reset and basic stream: first valid in cycle 2.
        do_reset(1'b0);
        #1;
        chk("c0_valid", ins_valid, 1'b0);
        chk("c0_ren", imem_ren, 1'b1);
        chk("c0_addr", 32'(imem_addr), 32'h0);
        tick(); #1;
        chk("c1_valid", ins_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("stream_valid", ins_valid, 1'b1);
            chk("stream_pc", ins_pc, 32'(4 * i));
            chk("stream_out", ins_out, mem_word(32'(4 * i)));
        end

        // Stall fills FIFO to DEPTH; release drains without gaps.
        do_reset(1'b1);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            #1;
            if (c >= 5) begin
                chk("stall_ren", imem_ren, 1'b0);
                chk("stall_valid", ins_valid, 1'b1);
                chk("stall_pc", ins_pc, 32'h0);
            end
        end
        tick(); stall = 1'b0; #1;
        chk("rel_pc0", ins_pc, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            tick(); #1;
            chk("rel_valid", ins_valid, 1'b1);
            chk("rel_pc", ins_pc, 32'(4 * i));
        end

        // Cross from local into the external region.
        rand_lat  = 1'b0;
        ex_lat    = 3;
        force_en  = 1'b1;
        force_val = 32'hDEAD_BEEF;
        tick(); br_en = 1'b1; br_addr = 32'h7F0; #1;
        tick(); br_en = 1'b0; #1;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            tick(); #1;
            seen = ex_req;
        end
        chk("x_req_seen", seen, 1'b1);
        chk("x_addr", ex_addr, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            tick(); #1;
            chk("x_req_hold", ex_req, 1'b1);
            chk("x_wait_valid", ins_valid, 1'b0);
        end
        tick(); #1;
        chk("x_valid", ins_valid, 1'b1);
        chk("x_pc", ins_pc, 32'h800);
        chk("x_out", ins_out, 32'hDEAD_BEEF);
        force_en = 1'b0;
        ex_lat   = 4;

        // Branch while an external request is outstanding: response dropped.
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            tick(); #1;
            seen = ex_req;
        end
        chk("d_req_seen", seen, 1'b1);
        br_en = 1'b1; br_addr = 32'h100;
        for (int k = 1; k <= 4; k++) begin
            tick(); br_en = 1'b0; #1;
            chk("d_req_hold", ex_req, 1'b1);
            chk("d_valid_low", ins_valid, 1'b0);
        end
        tick(); #1;
        chk("d_req_done", ex_req, 1'b0);
        chk("d_valid_low", ins_valid, 1'b0);
        tick(); #1;
        chk("d_valid_low", ins_valid, 1'b0);
        tick(); #1;
        chk("d_valid", ins_valid, 1'b1);
        chk("d_pc", ins_pc, 32'h100);
        chk("d_out", ins_out, mem_word(32'h100));

        // Branch coincident with pop and local push.
        tick(); br_en = 1'b1; br_addr = 32'h200; #1;
        chk("f_pop_valid", ins_valid, 1'b1);
        chk("f_no_issue", imem_ren, 1'b0);
        tick(); br_en = 1'b0; #1;
        chk("f_b1_valid", ins_valid, 1'b0);
        tick(); #1;
        chk("f_b2_valid", ins_valid, 1'b0);
        tick(); #1;
        chk("f_b3_valid", ins_valid, 1'b1);
        chk("f_b3_pc", ins_pc, 32'h200);
        chk("f_b3_out", ins_out, mem_word(32'h200));

        // Misaligned branch target.
        tick(); br_en = 1'b1; br_addr = 32'h102; #1;
        tick(); br_en = 1'b0; #1;
`ifdef IFETCH_MISALIGN_EN
        chk("m_pulse", misalign, 1'b1);
        tick(); #1;
        chk("m_pulse_end", misalign, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick(); #1;
            chk("m_halt_valid", ins_valid, 1'b0);
            chk("m_halt_ren", imem_ren, 1'b0);
        end
        tick(); br_en = 1'b1; br_addr = 32'h300; #1;
        tick(); br_en = 1'b0; #1;
        tick(); #1;
        tick(); #1;
        chk("m_resume_valid", ins_valid, 1'b1);
        chk("m_resume_pc", ins_pc, 32'h300);
`else
        chk("m_pulse", misalign, 1'b0);
        tick(); #1;
        chk("m_pulse", misalign, 1'b0);
        tick(); #1;
        chk("m_resume_valid", ins_valid, 1'b1);
        chk("m_resume_pc", ins_pc, 32'h100);
        chk("m_resume_out", ins_out, mem_word(32'h100));
`endif

        // Randomized stream against the program-order model.
        rand_lat = 1'b1;
        force_en = 1'b0;
        do_reset(1'b0);
        exp_pc    = 32'h0;
        last_out  = 32'h0;
        last_pc   = 32'h0;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_addr = 32'h0;
        pops      = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                tick();
                stall = ($urandom_range(0, 9) < 3);
                br_en = ($urandom_range(0, 99) < 3);
                if (br_en) br_addr = pick_target();
            end
            #1;
            if (ins_valid) begin
                chk("r_pc", ins_pc, exp_pc);
                chk("r_out", ins_out, mem_word(exp_pc));
                last_pc  = exp_pc;
                last_out = mem_word(exp_pc);
            end else begin
                chk("r_hold_pc", ins_pc, last_pc);
                chk("r_hold_out", ins_out, last_out);
            end
            if (prev_req && !prev_ack) begin
                chk("r_req_hold", ex_req, 1'b1);
                chk("r_addr_hold", ex_addr, prev_addr);
            end
            if (br_en) begin
                chk("r_br_no_issue", imem_ren, 1'b0);
                exp_pc = {br_addr[31:2], 2'b00};
            end else if (ins_valid && !stall) begin
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            prev_req  = ex_req;
            prev_ack  = ex_ack;
            prev_addr = ex_addr;
        end
        chk("r_progress", (pops > 200), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
